// File: rtl/n4_serial_deserializer_pkg.sv
// Shared definitions for the MSB-first serial deserializer:
// receiver state encoding and bit-counter width helpers.
package n4_serial_deserializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam int N_DEFAULT = 4;

  // Counter must be able to hold the value N itself, hence N+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(N_DEFAULT);

endpackage

// File: rtl/n4_serial_deserializer_lshift.sv
// Serial-input left shifter: new bit enters at the LSB so the first
// bit received ends up as the MSB once N bits have gone in.
module n_lshift_in #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_sr,
  input  logic         i_sin,
  output logic [N-1:0] o_sr
);

  assign o_sr = {i_sr[N-2:0], i_sin};

endmodule

// File: rtl/n4_serial_deserializer.sv
// Serial-in, parallel-out receiver with sof framing, a one-entry
// valid/ready holding register, and framing-error / overrun pulses.
module n4_serial_deserializer
  import n4_serial_deserializer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sof,
  output logic [N-1:0] z,
  output logic         z_valid,
  input  logic         z_ready,
  output logic         framing_err,
  output logic         overrun
);

  localparam int W_CNT = cnt_width(N);
  localparam logic [W_CNT-1:0] LAST_CNT = W_CNT'(N - 1);

  state_e           r_state, w_stateNext;
  logic [N-1:0]     r_sr, w_srNext, w_shift;
  logic [W_CNT-1:0] r_cnt, w_cntNext;
  logic [N-1:0]     r_z, w_zNext;
  logic             r_zValid, w_zValidNext;
  logic             r_framingErr, w_framingErrNext;
  logic             r_overrun, w_overrunNext;
  logic             w_complete;

  n_lshift_in #(.N(N)) u_shift (
    .i_sr  (r_sr),
    .i_sin (sin),
    .o_sr  (w_shift)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_z          <= '0;
      r_zValid     <= 1'b0;
      r_framingErr <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_sr         <= w_srNext;
      r_cnt        <= w_cntNext;
      r_z          <= w_zNext;
      r_zValid     <= w_zValidNext;
      r_framingErr <= w_framingErrNext;
      r_overrun    <= w_overrunNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_srNext         = r_sr;
    w_cntNext        = r_cnt;
    w_complete       = 1'b0;
    w_framingErrNext = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (sin_valid) begin
          if (sof) begin
            w_srNext    = w_shift;
            w_cntNext   = W_CNT'(1);
            w_stateNext = ST_RECV;
          end else begin
            w_framingErrNext = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (sin_valid) begin
          w_srNext = w_shift;
          // A fresh sof restarts the word; the partial one is silently dropped.
          if (sof) begin
            w_cntNext = W_CNT'(1);
          end else if (r_cnt == LAST_CNT) begin
            w_complete  = 1'b1;
            w_cntNext   = '0;
            w_stateNext = ST_IDLE;
          end else begin
            w_cntNext = r_cnt + W_CNT'(1);
          end
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    w_zNext       = r_z;
    w_zValidNext  = r_zValid;
    w_overrunNext = 1'b0;
    // A completion always loads; overrun only if the old word was never taken.
    if (w_complete) begin
      w_zNext       = w_shift;
      w_zValidNext  = 1'b1;
      w_overrunNext = r_zValid && !z_ready;
    end else if (r_zValid && z_ready) begin
      w_zValidNext = 1'b0;
    end
  end

  assign z           = r_z;
  assign z_valid     = r_zValid;
  assign framing_err = r_framingErr;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_n4_serial_deserializer.sv
// Directed table-driven bench for n4_serial_deserializer (N=4) plus a
// hand-written reset-mid-word sequence.
module tb_n4_serial_deserializer;

  typedef struct {
    logic       rst;
    logic       sv;
    logic       sf;
    logic       bit_;
    logic       rdy;
    logic [3:0] expZ;
    logic       expZv;
    logic       expFe;
    logic       expOv;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset, sin, sinValid, sof, zReady;
  logic [3:0] z;
  logic       zValid, framingErr, overrun;

  int vectorCount = 0;
  int missCount   = 0;

  vec_t vecs[38];

  n4_serial_deserializer #(.N(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sinValid),
    .sof         (sof),
    .z           (z),
    .z_valid     (zValid),
    .z_ready     (zReady),
    .framing_err (framingErr),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic r, input logic v, input logic f,
                               input logic b, input logic rd);
    reset    = r;
    sinValid = v;
    sof      = f;
    sin      = b;
    zReady   = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ez,
                             input logic ezv, input logic efe, input logic eov);
    vectorCount++;
    if (z !== ez || zValid !== ezv || framingErr !== efe || overrun !== eov) begin
      missCount++;
      $display("[TB] FAIL %s: got z=%b zv=%b fe=%b ov=%b, expected z=%b zv=%b fe=%b ov=%b",
               name, z, zValid, framingErr, overrun, ez, ezv, efe, eov);
    end
  endtask

  initial begin
    // rst sv sof sin rdy | z zv fe ov
    vecs[0]  = '{1,0,0,0,0, 4'b0000,0,0,0};
    vecs[1]  = '{0,1,1,1,0, 4'b0000,0,0,0};
    vecs[2]  = '{0,1,0,0,0, 4'b0000,0,0,0};
    vecs[3]  = '{0,1,0,1,0, 4'b0000,0,0,0};
    vecs[4]  = '{0,1,0,1,0, 4'b1011,1,0,0};
    vecs[5]  = '{0,0,0,0,0, 4'b1011,1,0,0};
    vecs[6]  = '{0,0,0,0,1, 4'b1011,0,0,0};
    vecs[7]  = '{0,1,1,0,0, 4'b1011,0,0,0};
    vecs[8]  = '{0,1,0,1,0, 4'b1011,0,0,0};
    vecs[9]  = '{0,1,0,1,0, 4'b1011,0,0,0};
    vecs[10] = '{0,1,0,0,0, 4'b0110,1,0,0};
    vecs[11] = '{0,1,1,1,0, 4'b0110,1,0,0};
    vecs[12] = '{0,1,0,0,0, 4'b0110,1,0,0};
    vecs[13] = '{0,1,0,0,0, 4'b0110,1,0,0};
    vecs[14] = '{0,1,0,1,0, 4'b1001,1,0,1};
    vecs[15] = '{0,0,0,0,0, 4'b1001,1,0,0};
    vecs[16] = '{0,1,1,1,0, 4'b1001,1,0,0};
    vecs[17] = '{0,1,0,1,0, 4'b1001,1,0,0};
    vecs[18] = '{0,1,0,1,0, 4'b1001,1,0,0};
    vecs[19] = '{0,1,0,0,1, 4'b1110,1,0,0};
    vecs[20] = '{0,0,0,0,1, 4'b1110,0,0,0};
    vecs[21] = '{0,1,0,1,0, 4'b1110,0,1,0};
    vecs[22] = '{0,0,0,0,0, 4'b1110,0,0,0};
    vecs[23] = '{0,1,0,0,0, 4'b1110,0,1,0};
    vecs[24] = '{0,1,0,1,0, 4'b1110,0,1,0};
    vecs[25] = '{0,0,0,0,0, 4'b1110,0,0,0};
    vecs[26] = '{0,1,1,0,0, 4'b1110,0,0,0};
    vecs[27] = '{0,1,0,0,0, 4'b1110,0,0,0};
    vecs[28] = '{0,1,0,1,0, 4'b1110,0,0,0};
    vecs[29] = '{0,1,0,1,0, 4'b0011,1,0,0};
    vecs[30] = '{0,0,0,0,1, 4'b0011,0,0,0};
    vecs[31] = '{0,1,1,1,0, 4'b0011,0,0,0};
    vecs[32] = '{0,1,0,0,0, 4'b0011,0,0,0};
    vecs[33] = '{0,1,1,1,0, 4'b0011,0,0,0};
    vecs[34] = '{0,0,0,0,0, 4'b0011,0,0,0};
    vecs[35] = '{0,1,0,1,0, 4'b0011,0,0,0};
    vecs[36] = '{0,1,0,0,0, 4'b0011,0,0,0};
    vecs[37] = '{0,1,0,0,0, 4'b1100,1,0,0};

    reset = 1'b1; sin = 1'b0; sinValid = 1'b0; sof = 1'b0; zReady = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 38; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].sv, vecs[i].sf, vecs[i].bit_, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].expZ, vecs[i].expZv,
                  vecs[i].expFe, vecs[i].expOv);
    end

    // Reset arriving three bits into a word while an older word is pending.
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("mid_word_before_reset", 4'b1100, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("reset_mid_word", 4'b0000, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("idle_after_reset", 4'b0000, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("frame_0101_partial", 4'b0000, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("frame_0101", 4'b0101, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("consume_0101", 4'b0101, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ready_while_empty", 4'b0101, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/n4_serial_deserializer.md
Name: n4_serial_deserializer

Overview:
- Serial-in, parallel-out receiver: the other end of the parallel-load left-shift register used as an MSB-first serial transmitter.
- Accepts one bit per strobe, MSB first, with a start-of-frame marker.
- Assembles N-bit words and presents each word through a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns. Sits between a serial link and any parallel consumer.

Parameters:
- N, 4, word width in bits (N >= 2).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- sin  in  1  serial data bit.
- sin_valid  in  1  bit strobe; sin and sof are sampled only when high.
- sof  in  1  start-of-frame; qualifies the current bit as the MSB of a new word.
- z  out  N  received word (holding register), MSB = first bit received.
- z_valid  out  1  holding register contains an unconsumed word.
- z_ready  in  1  consumer accepts z when z_valid && z_ready at posedge.
- framing_err  out  1  one-cycle pulse: bit strobe without sof while IDLE.
- overrun  out  1  one-cycle pulse: an unconsumed word was overwritten.

Behaviour:
- Reset (reset=1 at posedge) has priority over all other inputs and applies in any state, including mid-word:
  - state=IDLE, shift register=0, count=0, z=0, z_valid=0, framing_err=0, overrun=0.
  - A partial word is discarded.
- Internal state: shift register SR[N-1:0], bit counter cnt of width clog2(N+1), state in {IDLE, RECV}.
- Shift rule: SR <= {SR[N-2:0], sin}, i.e. left shift with the new bit entering at the LSB.
- IDLE:
  - sin_valid && sof: SR <= {SR[N-2:0], sin}, cnt <= 1, go to RECV.
  - sin_valid && !sof: bit dropped, framing_err=1 for the next cycle, stay in IDLE.
  - !sin_valid: hold.
- RECV:
  - sin_valid && sof: resynchronise. Discard the partial word; SR <= {SR[N-2:0], sin}, cnt <= 1, stay in RECV. No error flagged.
  - sin_valid && !sof: shift, cnt <= cnt+1.
  - !sin_valid: hold. There is no timeout.
- Word completion: the bit that makes cnt reach N (the N-th bit) completes the word on that edge.
  - z <= completed word, z_valid <= 1, cnt <= 0, state <= IDLE.
  - Latency: z_valid is high in the cycle right after the edge that sampled the last bit.
- Handshake:
  - z_valid && z_ready at posedge with no completion: z_valid <= 0, z holds its value.
  - z_valid stays high until accepted or until reset.
  - z_ready while z_valid=0 is ignored.
- Simultaneous completion and handshake:
  - z_valid=1, z_ready=1, word completes on the same edge: old word is consumed, new word is loaded, z_valid stays 1, no overrun.
  - z_valid=1, z_ready=0, word completes: z is overwritten with the new word, z_valid stays 1, overrun=1 for one cycle.
- N=1 with sof while IDLE is excluded by the parameter constraint.
- framing_err and overrun are registered pulses, each high for exactly one cycle per event. Back-to-back events produce consecutive high cycles.
- Back-to-back words: sof may arrive on the strobe immediately after the completing bit. There are no idle cycles between words.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_RECV=1) and the counter-width constant CNT_W = clog2(N+1).
- One natural sub-module: n_lshift_in, combinational. Takes SR and sin and returns {SR[N-2:0], sin}. It is the serial-input counterpart of the existing left shifter.

Test Plan:
- Reset, then strobe sof=1/sin=1, then sin=0,1,1 with sof=0 (N=4) -> z_valid rises the cycle after the 4th bit, z=4'b1011, no error pulses.
- Word 4'b0110 held with z_ready=0, then a second word 4'b1001 completes -> z=4'b1001, z_valid=1, overrun high exactly one cycle.
- Word pending, z_ready=1 on the same edge that completes 4'b1110 -> z=4'b1110, z_valid stays 1, overrun stays 0; next cycle with z_ready=1 -> z_valid=0.
- IDLE, strobe with sof=0 -> framing_err one-cycle pulse, z_valid unchanged; a following valid frame 4'b0011 is received correctly.
- Two bits of a frame, then a new sof with 4'b1100 -> partial word discarded, z=4'b1100, no error pulses.
- reset asserted after 3 bits while z_valid=1 -> next cycle z=0, z_valid=0, state IDLE; a subsequent full frame 4'b0101 is received correctly.
